// File: rtl/spi_frame_pkg.sv
// Shared definitions for framing sensor samples onto the 16-bit SPI slave write path.
// Used by sensor_spi_scheduler and its round-robin arbiter.
package spi_frame_pkg;

  localparam int         WORD_W    = 16;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    TRAILER,
    DONE
  } state_t;

  // Number of 16-bit payload words carrying a 2*bitwidth sample.
  function automatic int npay(input int bitwidth);
    return (2 * bitwidth) / WORD_W;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Grant index is binary; gnt_vld is low when no request is set.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  int j;

  // Scan offsets from the far end so the nearest request to ptr is written last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sensor_spi_scheduler.sv
// Round-robin scheduler framing one sensor sample at a time onto the SPI slave write path.
// Optional checksum trailer word enabled by defining SPI_FRAME_CHECKSUM_EN.
module sensor_spi_scheduler
  import spi_frame_pkg::*;
#(
  parameter int SENSORS  = 4,
  parameter int BITWIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SENSORS-1:0]              req,
  input  logic [2*SENSORS*BITWIDTH-1:0]   data,
  output logic [SENSORS-1:0]              ack,
  output logic                            write,
  input  logic                            write_ready,
  output logic [15:0]                     write_data,
  output logic                            busy,
  output logic [3:0]                      seq
);

  localparam int SMP_W = 2 * BITWIDTH;
  localparam int NPAY  = npay(BITWIDTH);
  localparam int CH_W  = (SENSORS > 1) ? $clog2(SENSORS) : 1;
  localparam int IDX_W = (NPAY > 1) ? $clog2(NPAY) : 1;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   chan_q;
  logic [CH_W-1:0]   rr_q;
  logic [SMP_W-1:0]  snap_q;
  logic [IDX_W-1:0]  widx_q;
  logic [3:0]        seq_q;

  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;
  logic [3:0]        hdr_chan;
  logic              last_word;
  logic [SMP_W-1:0]  snap_shift;
  logic [WORD_W-1:0] word_cur;

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q;
`endif

  rr_arbiter #(.N(SENSORS)) u_arb (
    .req     (req),
    .ptr     (rr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Most-significant word first: shift the current word to the top of the snapshot.
  assign snap_shift = snap_q << (int'(widx_q) * WORD_W);
  assign word_cur   = snap_shift[SMP_W-1 -: WORD_W];
  assign last_word  = (widx_q == IDX_W'(NPAY - 1));
  assign hdr_chan   = 4'(chan_q);
  assign seq        = seq_q;

  always_comb begin
    state_d    = state_q;
    write      = 1'b0;
    write_data = '0;
    busy       = 1'b0;
    ack        = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = HEADER;
      end
      HEADER: begin
        write      = 1'b1;
        busy       = 1'b1;
        write_data = {HDR_MAGIC, seq_q, 4'h0, hdr_chan};
        if (write_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        write      = 1'b1;
        busy       = 1'b1;
        write_data = word_cur;
`ifdef SPI_FRAME_CHECKSUM_EN
        if (write_ready && last_word) state_d = TRAILER;
`else
        if (write_ready && last_word) state_d = DONE;
`endif
      end
`ifdef SPI_FRAME_CHECKSUM_EN
      TRAILER: begin
        write      = 1'b1;
        busy       = 1'b1;
        write_data = csum_q;
        if (write_ready) state_d = DONE;
      end
`endif
      DONE: begin
        ack[chan_q] = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
      rr_q    <= '0;
      snap_q  <= '0;
      widx_q  <= '0;
      seq_q   <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            chan_q <= gnt_idx;
            snap_q <= data[int'(gnt_idx)*SMP_W +: SMP_W];
            widx_q <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        PAYLOAD: begin
          if (write_ready) begin
            widx_q <= widx_q + 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum_q <= csum_q ^ word_cur;
`endif
          end
        end
        DONE: begin
          seq_q <= seq_q + 1'b1;
          rr_q  <= (chan_q == CH_W'(SENSORS - 1)) ? '0 : chan_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_spi_scheduler.sv
// Randomized bench for sensor_spi_scheduler against a word-queue reference model.
// Honours SPI_FRAME_CHECKSUM_EN to expect the trailer word.
module tb_sensor_spi_scheduler;

  localparam int SENSORS  = 4;
  localparam int BITWIDTH = 32;
  localparam int SMP_W    = 2 * BITWIDTH;
  localparam int DW       = SENSORS * SMP_W;
  localparam int NPAY     = SMP_W / 16;
`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [SENSORS-1:0] req;
  logic [DW-1:0]      data;
  logic [SENSORS-1:0] ack;
  logic               write;
  logic               write_ready;
  logic [15:0]        write_data;
  logic               busy;
  logic [3:0]         seq;

  sensor_spi_scheduler #(.SENSORS(SENSORS), .BITWIDTH(BITWIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .write       (write),
    .write_ready (write_ready),
    .write_data  (write_data),
    .busy        (busy),
    .seq         (seq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: pending words of the current frame, plus frame bookkeeping.
  logic [15:0] q[$];
  bit          m_done = 0;
  int          m_chan = 0;
  int          m_rr   = 0;
  logic [3:0]  m_seq  = '0;

  bit          cap_en = 0;
  logic [15:0] cap[$];
  int          ack_log[$];
  int          n_acks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Applies what the next rising edge does given the inputs now on the pins.
  task automatic model_advance();
    int          c;
    logic [SMP_W-1:0] s;
    logic [15:0] x;
    logic [15:0] w;
    if (!rst) begin
      q.delete();
      m_done = 0;
      m_seq  = '0;
      m_rr   = 0;
    end else if (m_done) begin
      m_done = 0;
      m_seq  = m_seq + 4'd1;
      m_rr   = (m_chan + 1) % SENSORS;
    end else if (q.size() > 0) begin
      if (write_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1;
      end
    end else if (req != '0) begin
      c = -1;
      for (int i = 0; i < SENSORS; i++)
        if (c < 0 && req[(m_rr + i) % SENSORS]) c = (m_rr + i) % SENSORS;
      m_chan = c;
      s = data[c*SMP_W +: SMP_W];
      q.push_back({4'hA, m_seq, 4'h0, 4'(c)});
      x = '0;
      for (int k = 0; k < NPAY; k++) begin
        w = s[(NPAY - 1 - k)*16 +: 16];
        q.push_back(w);
        x = x ^ w;
      end
      if (CK != 0) q.push_back(x);
    end
  endtask

  task automatic step();
    logic        ew;
    logic [15:0] ed;
    logic [SENSORS-1:0] ea;
    if (cap_en && write && write_ready) cap.push_back(write_data);
    model_advance();
    @(negedge clk);
    cyc++;
    ew = !m_done && (q.size() > 0);
    ed = ew ? q[0] : 16'h0;
    ea = m_done ? SENSORS'(1 << m_chan) : '0;
    check_eq("write", write, ew);
    check_eq("write_data", write_data, ed);
    check_eq("busy", busy, ew);
    check_eq("ack", ack, ea);
    check_eq("seq", seq, m_seq);
    if (ack != '0) begin
      n_acks++;
      for (int c = 0; c < SENSORS; c++) if (ack[c]) ack_log.push_back(c);
    end
  endtask

  task automatic drain();
    req = '0;
    write_ready = 1'b1;
    for (int i = 0; i < 60 && (m_done || q.size() > 0); i++) step();
    step();
  endtask

  logic [15:0] ch1_exp [5] = '{16'hA001, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
  int a0;

  initial begin
    rst = 1'b0; req = '0; data = '0; write_ready = 1'b1;
    repeat (3) step();
    check_eq("reset_seq", seq, 4'h0);
    rst = 1'b1;

    // Single channel-1 frame with known payload.
    data = rand_data();
    data[SMP_W +: SMP_W] = SMP_W'(64'h1111_2222_3333_4444);
    req = 4'b0010;
    cap.delete();
    cap_en = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_done) req = '0;
    end
    cap_en = 0;
    check_eq("ch1_len", cap.size(), 5 + CK);
    for (int i = 0; i < 5 && i < cap.size(); i++) check_eq("ch1_word", cap[i], ch1_exp[i]);
`ifdef SPI_FRAME_CHECKSUM_EN
    if (cap.size() > 5) check_eq("ch1_trailer", cap[5], 16'h4444);
`endif

    // All channels requesting: 20 frames, order continues from channel 2.
    ack_log.delete();
    req = '1;
    for (int i = 0; i < 400 && ack_log.size() < 20; i++) begin
      data = rand_data();
      step();
    end
    check_eq("rr_count", ack_log.size() >= 20, 1'b1);
    for (int i = 0; i < ack_log.size(); i++) check_eq("rr_order", ack_log[i], (2 + i) % SENSORS);
    drain();

    // Slave accepting one cycle in three.
    req = 4'($urandom_range(1, 15));
    for (int i = 0; i < 90; i++) begin
      write_ready = (cyc % 3 == 0);
      data = rand_data();
      step();
    end
    drain();

    // Channel 2 drops req and changes data once the header is accepted.
    ack_log.delete();
    data = rand_data();
    req  = 4'b0100;
    for (int i = 0; i < 10 && q.size() != NPAY + CK; i++) step();
    data = rand_data();
    req  = '0;
    for (int i = 0; i < 12; i++) step();
    check_eq("ch2_ack_count", ack_log.size(), 1);
    if (ack_log.size() > 0) check_eq("ch2_ack_chan", ack_log[0], 2);
    drain();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      write_ready = ($urandom_range(0, 9) < 7);
      data = rand_data();
      step();
    end
    drain();

    // Reset while payload word 2 is on the bus.
    req  = 4'b0001;
    data = rand_data();
    for (int i = 0; i < 10 && q.size() != NPAY + CK - 2; i++) step();
    check_eq("pre_rst_in_payload", q.size(), NPAY + CK - 2);
    rst = 1'b0;
    req = '0;
    step();
    check_eq("rst_write", write, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b1;
    a0 = n_acks;
    for (int i = 0; i < 6; i++) step();
    check_eq("rst_no_ack", n_acks - a0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
